clcd_bus_driver: RTL and testbench
==================================

Name: clcd_bus_driver

Overview:
- Responder end of the character-LCD start/done handshake. Display sequencers such as the UP/DOWN banner present one byte plus RS and raise iStart.
- The block latches the request and generates HD44780-compatible bus timing on LCD_DATA/LCD_RS/LCD_RW/LCD_EN.
- It waits the controller's execution time, then returns oDone.
- It sits between any clcd_* sequencer and the physical LCD pins.

Parameters:
- SETUP_CYC, 4: iCLK cycles RS/RW/DATA stable before EN rises (tAS, 80 ns at 50 MHz).
- EN_CYC, 16: iCLK cycles LCD_EN held high (PW_EH, 320 ns).
- HOLD_CYC, 4: iCLK cycles RS/RW/DATA held after EN falls (tH).
- EXEC_CYC, 2500: post-write wait for normal commands and data (50 us).
- CLR_EXEC_CYC, 82000: post-write wait for clear (0x01) and home (0x02/0x03) with RS=0 (1.64 ms).

Ports:
- iCLK, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- iDATA, input, 8: byte to write; sampled on request acceptance.
- iRS, input, 1: register select for the request; 0 = instruction, 1 = data.
- iStart, input, 1: request level; held by the initiator until oDone is seen.
- oDone, output, 1: completion; high from end of transfer until iStart falls.
- LCD_DATA, output, 8: LCD data bus.
- LCD_RW, output, 1: LCD read/write; 0 = write.
- LCD_EN, output, 1: LCD enable strobe.
- LCD_RS, output, 1: LCD register select.

Behaviour:
- Reset values: oDone=0, LCD_DATA=0x00, LCD_RW=0, LCD_EN=0, LCD_RS=0. FSM goes to IDLE and the cycle counter (18-bit) is cleared.
- Reset asserted mid-transfer aborts on the next edge. EN drops immediately and no oDone is issued.
- FSM states: IDLE, SETUP, STROBE, HOLD, EXEC, DONE.
- IDLE: when iStart=1, latch iDATA into LCD_DATA and iRS into LCD_RS. Select the exec limit: CLR_EXEC_CYC if iRS=0 and iDATA[7:2]=0, else EXEC_CYC. Go to SETUP with the counter at 0.
- SETUP: count SETUP_CYC cycles, then go to STROBE. LCD_EN=1 during STROBE only.
- STROBE: LCD_EN high for exactly EN_CYC cycles, then go to HOLD.
- HOLD: count HOLD_CYC cycles with LCD_EN=0 and the bus unchanged, then go to EXEC.
- EXEC: count the selected exec limit, then go to DONE.
- DONE: oDone=1. Stay until iStart=0; oDone drops on the cycle after iStart is sampled low, and the FSM returns to IDLE.
- Four-phase handshake: one request yields exactly one EN pulse. iStart held high after DONE does not retrigger.
- iStart dropping before DONE is ignored. The transfer completes and DONE exits on the first cycle iStart is low, giving a 1-cycle oDone pulse.
- iDATA/iRS changes after acceptance have no effect until the next IDLE acceptance.
- Fixed latency per write:
  - Normal: SETUP_CYC + EN_CYC + HOLD_CYC + EXEC_CYC cycles from acceptance to oDone, i.e. 2524 with defaults.
  - Clear/home: 82024 cycles with defaults.
- LCD_DATA and LCD_RS keep their last value in IDLE. LCD_RW is constant 0 unless the optional feature is enabled.
- A parameter value of 0 means the corresponding state lasts 1 cycle; the minimum is always 1.

Optional Feature:
- Macro: CLCD_BUSY_POLL_EN. When defined, two extra ports exist: LCD_DATA_IN (input, 8) and LCD_DATA_OE (output, 1, reset 0).
- LCD_DATA_OE=1 during SETUP/STROBE/HOLD of a write.
- EXEC is replaced by a busy-poll loop:
  - OE=0, RS=0, RW=1.
  - Then SETUP_CYC, EN high for EN_CYC, sample LCD_DATA_IN[7] on the last EN-high cycle, then HOLD_CYC.
  - Repeat while the busy flag is 1.
- On busy=0, go to DONE with RW=0.
- Timeout: if the total poll time reaches CLR_EXEC_CYC, go to DONE anyway.
- Without the macro: no extra ports and a fixed EXEC delay.

Test Plan:
- Reset, then iStart=1 with iDATA=0x38, iRS=0:
  - LCD_DATA=0x38 and RS=0 one cycle after acceptance.
  - EN high exactly 16 cycles starting 4 cycles later.
  - oDone rises 2524 cycles after acceptance.
  - oDone falls 1 cycle after iStart=0.
- Write iDATA=0x01, iRS=0 -> oDone at 82024 cycles. Repeat with 0x55, iRS=1 -> oDone at 2524 with LCD_RS=1.
- Hold iStart high for 10000 cycles after oDone -> exactly one EN pulse is counted and oDone stays 1.
- Change iDATA 0x44 -> 0x4E during STROBE -> LCD_DATA stays 0x44 until the next request.
- Assert reset during EXEC of 0x0C -> next cycle all outputs are at reset values. A new request then completes normally.
- With CLCD_BUSY_POLL_EN, model the busy flag as 1 for 3 polls then 0 -> 1 write pulse plus 4 read pulses with RW=1 and OE=0, then oDone.

Source files
------------

// File: rtl/clcd_bus_driver.sv
// HD44780 write-bus timing generator answering a level start/done handshake.
// Define CLCD_BUSY_POLL_EN to replace the fixed execution wait with busy-flag polling.
module clcd_bus_driver #(
    parameter int unsigned SETUP_CYC    = 4,
    parameter int unsigned EN_CYC       = 16,
    parameter int unsigned HOLD_CYC     = 4,
    parameter int unsigned EXEC_CYC     = 2500,
    parameter int unsigned CLR_EXEC_CYC = 82000
) (
    input  logic       iCLK,
    input  logic       reset,
    input  logic [7:0] iDATA,
    input  logic       iRS,
    input  logic       iStart,
    output logic       oDone,
    output logic [7:0] LCD_DATA,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic       LCD_RS
`ifdef CLCD_BUSY_POLL_EN
    ,
    input  logic [7:0] LCD_DATA_IN,
    output logic       LCD_DATA_OE
`endif
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETUP  = 3'd1;
    localparam logic [2:0] ST_STROBE = 3'd2;
    localparam logic [2:0] ST_HOLD   = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // Terminal counter values; a zero parameter still yields a one-cycle state.
    localparam logic [17:0] LAST_SETUP = (SETUP_CYC == 0) ? 18'd0 : 18'(SETUP_CYC - 1);
    localparam logic [17:0] LAST_EN    = (EN_CYC == 0) ? 18'd0 : 18'(EN_CYC - 1);
    localparam logic [17:0] LAST_HOLD  = (HOLD_CYC == 0) ? 18'd0 : 18'(HOLD_CYC - 1);
    localparam logic [17:0] LAST_EXEC  = (EXEC_CYC == 0) ? 18'd0 : 18'(EXEC_CYC - 1);
    localparam logic [17:0] LAST_CLR   = (CLR_EXEC_CYC == 0) ? 18'd0 : 18'(CLR_EXEC_CYC - 1);

    logic [2:0]  r_state;
    logic [17:0] r_cnt;
    logic [17:0] r_exec_last;
    logic [7:0]  r_data;
    logic        r_rs;
    logic        r_rw;
    logic        r_en;
    logic        r_done;

    logic [2:0]  w_state_nx;
    logic [17:0] w_cnt_nx;
    logic [17:0] w_exec_last_nx;
    logic [7:0]  w_data_nx;
    logic        w_rs_nx;
    logic        w_rw_nx;
    logic        w_en_nx;
    logic        w_done_nx;

`ifdef CLCD_BUSY_POLL_EN
    logic        r_oe;
    logic        r_busy;
    logic [17:0] r_poll_cnt;
    logic        w_oe_nx;
    logic        w_busy_nx;
    logic [17:0] w_poll_cnt_nx;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt + 18'd1;
        w_exec_last_nx = r_exec_last;
        w_data_nx      = r_data;
        w_rs_nx        = r_rs;
        w_rw_nx        = r_rw;
        w_en_nx        = r_en;
        w_done_nx      = r_done;
`ifdef CLCD_BUSY_POLL_EN
        w_oe_nx        = r_oe;
        w_busy_nx      = r_busy;
        w_poll_cnt_nx  = r_rw ? (r_poll_cnt + 18'd1) : 18'd0;
`endif
        case (r_state)
            ST_IDLE: begin
                w_cnt_nx = '0;
                if (iStart) begin
                    w_data_nx      = iDATA;
                    w_rs_nx        = iRS;
                    // Clear and return-home execute far slower than other instructions.
                    w_exec_last_nx = (!iRS && (iDATA[7:2] == 6'd0)) ? LAST_CLR : LAST_EXEC;
                    w_state_nx     = ST_SETUP;
`ifdef CLCD_BUSY_POLL_EN
                    w_oe_nx        = 1'b1;
`endif
                end
            end
            ST_SETUP: begin
                if (r_cnt == LAST_SETUP) begin
                    w_state_nx = ST_STROBE;
                    w_cnt_nx   = '0;
                    w_en_nx    = 1'b1;
                end
            end
            ST_STROBE: begin
`ifdef CLCD_BUSY_POLL_EN
                if (r_rw && (r_cnt == LAST_EN)) begin
                    w_busy_nx = LCD_DATA_IN[7];
                end
`endif
                if (r_cnt == LAST_EN) begin
                    w_state_nx = ST_HOLD;
                    w_cnt_nx   = '0;
                    w_en_nx    = 1'b0;
                end
            end
            ST_HOLD: begin
                if (r_cnt == LAST_HOLD) begin
                    w_cnt_nx = '0;
`ifdef CLCD_BUSY_POLL_EN
                    if (!r_rw) begin
                        // Write finished: release the bus and start reading the busy flag.
                        w_state_nx    = ST_SETUP;
                        w_oe_nx       = 1'b0;
                        w_rs_nx       = 1'b0;
                        w_rw_nx       = 1'b1;
                        w_poll_cnt_nx = '0;
                    end else if (r_busy) begin
                        w_state_nx = ST_SETUP;
                    end else begin
                        w_state_nx = ST_DONE;
                        w_rw_nx    = 1'b0;
                        w_done_nx  = 1'b1;
                    end
`else
                    w_state_nx = ST_EXEC;
`endif
                end
            end
            ST_EXEC: begin
                if (r_cnt == r_exec_last) begin
                    w_state_nx = ST_DONE;
                    w_cnt_nx   = '0;
                    w_done_nx  = 1'b1;
                end
            end
            ST_DONE: begin
                w_cnt_nx = '0;
                if (!iStart) begin
                    w_state_nx = ST_IDLE;
                    w_done_nx  = 1'b0;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
                w_en_nx    = 1'b0;
                w_done_nx  = 1'b0;
            end
        endcase
`ifdef CLCD_BUSY_POLL_EN
        // Give up on a flag that never clears.
        if (r_rw && (r_poll_cnt == LAST_CLR)) begin
            w_state_nx = ST_DONE;
            w_cnt_nx   = '0;
            w_en_nx    = 1'b0;
            w_rw_nx    = 1'b0;
            w_done_nx  = 1'b1;
        end
`endif
    end

    always_ff @(posedge iCLK) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_exec_last <= '0;
            r_data      <= '0;
            r_rs        <= 1'b0;
            r_rw        <= 1'b0;
            r_en        <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_cnt       <= w_cnt_nx;
            r_exec_last <= w_exec_last_nx;
            r_data      <= w_data_nx;
            r_rs        <= w_rs_nx;
            r_rw        <= w_rw_nx;
            r_en        <= w_en_nx;
            r_done      <= w_done_nx;
        end
    end

`ifdef CLCD_BUSY_POLL_EN
    always_ff @(posedge iCLK) begin
        if (reset) begin
            r_oe       <= 1'b0;
            r_busy     <= 1'b0;
            r_poll_cnt <= '0;
        end else begin
            r_oe       <= w_oe_nx;
            r_busy     <= w_busy_nx;
            r_poll_cnt <= w_poll_cnt_nx;
        end
    end

    assign LCD_DATA_OE = r_oe;
`endif

    assign oDone    = r_done;
    assign LCD_DATA = r_data;
    assign LCD_RW   = r_rw;
    assign LCD_EN   = r_en;
    assign LCD_RS   = r_rs;

endmodule

// File: tb/tb_clcd_bus_driver.sv
// Scoreboard bench for clcd_bus_driver; the clear/home wait is shortened to keep the run brief,
// and a second instance with all timing parameters at 0 covers the one-cycle minimum.
module tb_clcd_bus_driver;

    localparam int SETUP_CYC = 4;
    localparam int EN_CYC    = 16;
    localparam int HOLD_CYC  = 4;
    localparam int EXEC_CYC  = 2500;
    localparam int CLR_CYC   = 8200;
    localparam int LAT_NORM  = 2524;
    localparam int LAT_CLR   = 8224;

    typedef struct packed {
        int         acc;
        int         lat;
        logic [7:0] data;
        logic       rs;
    } exp_t;

    logic       iCLK = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] iDATA = 8'h00;
    logic       iRS = 1'b0;
    logic       iStart = 1'b0;
    logic       oDone;
    logic [7:0] LCD_DATA;
    logic       LCD_RW;
    logic       LCD_EN;
    logic       LCD_RS;

    logic [7:0] m_data = 8'h00;
    logic       m_rs = 1'b0;
    logic       m_start = 1'b0;
    logic       m_done;
    logic [7:0] m_lcd_data;
    logic       m_rw;
    logic       m_en;
    logic       m_lcd_rs;

    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;
    int   en_pulses = 0;
    int   en_start = 0;
    logic prev_en = 1'b0;
    logic prev_done = 1'b0;
    exp_t sb_q[$];

    clcd_bus_driver #(
        .SETUP_CYC   (SETUP_CYC),
        .EN_CYC      (EN_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .EXEC_CYC    (EXEC_CYC),
        .CLR_EXEC_CYC(CLR_CYC)
    ) u_dut (
        .iCLK    (iCLK),
        .reset   (reset),
        .iDATA   (iDATA),
        .iRS     (iRS),
        .iStart  (iStart),
        .oDone   (oDone),
        .LCD_DATA(LCD_DATA),
        .LCD_RW  (LCD_RW),
        .LCD_EN  (LCD_EN),
        .LCD_RS  (LCD_RS)
    );

    clcd_bus_driver #(
        .SETUP_CYC   (0),
        .EN_CYC      (0),
        .HOLD_CYC    (0),
        .EXEC_CYC    (0),
        .CLR_EXEC_CYC(0)
    ) u_dut_min (
        .iCLK    (iCLK),
        .reset   (reset),
        .iDATA   (m_data),
        .iRS     (m_rs),
        .iStart  (m_start),
        .oDone   (m_done),
        .LCD_DATA(m_lcd_data),
        .LCD_RW  (m_rw),
        .LCD_EN  (m_en),
        .LCD_RS  (m_lcd_rs)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d (0x%0h) expected=%0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Monitor: samples on the falling edge and retires scoreboard entries on oDone.
    initial begin
        exp_t e;
        forever begin
            @(negedge iCLK);
            if (!reset) begin
                if (sb_q.size() > 0 && cyc == sb_q[0].acc) begin
                    check_eq("data_latch", 32'(LCD_DATA), 32'(sb_q[0].data));
                    check_eq("rs_latch", 32'(LCD_RS), 32'(sb_q[0].rs));
                end
                if (LCD_EN && !prev_en) begin
                    en_start = cyc;
                    en_pulses++;
                    check_eq("rw_write", 32'(LCD_RW), 0);
                    if (sb_q.size() > 0) check_eq("setup_delay", cyc - sb_q[0].acc, SETUP_CYC);
                end
                if (!LCD_EN && prev_en) begin
                    check_eq("en_width", cyc - en_start, EN_CYC);
                    if (sb_q.size() > 0) check_eq("hold_data", 32'(LCD_DATA), 32'(sb_q[0].data));
                end
                if (oDone && !prev_done) begin
                    if (sb_q.size() == 0) begin
                        check_eq("spurious_done", 1, 0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq("latency", cyc - e.acc, e.lat);
                        check_eq("done_data", 32'(LCD_DATA), 32'(e.data));
                        check_eq("done_rs", 32'(LCD_RS), 32'(e.rs));
                    end
                end
            end
            prev_en   = LCD_EN;
            prev_done = oDone;
        end
    end

    task automatic do_write(input logic [7:0] d, input logic rs, input logic [7:0] d_late,
                            input int lat, input int hold_after);
        exp_t e;
        int   n0;
        bit   seen;
        bit   held;
        @(negedge iCLK);
        iDATA  = d;
        iRS    = rs;
        iStart = 1'b1;
        e.acc  = cyc + 1;
        e.lat  = lat;
        e.data = d;
        e.rs   = rs;
        sb_q.push_back(e);
        n0 = en_pulses;
        while (cyc < e.acc + 10) @(negedge iCLK);
        iDATA = d_late;
        iRS   = ~rs;
        seen  = 1'b0;
        for (int i = 0; i < lat + 100; i++) begin
            @(negedge iCLK);
            if (oDone) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("done_seen", 32'(seen), 1);
        held = 1'b1;
        for (int i = 0; i < hold_after; i++) begin
            @(negedge iCLK);
            if (!oDone) held = 1'b0;
        end
        check_eq("done_held", 32'(held), 1);
        check_eq("one_en_pulse", en_pulses - n0, 1);
        iStart = 1'b0;
        @(negedge iCLK);
        check_eq("done_fall", 32'(oDone), 0);
        check_eq("data_kept", 32'(LCD_DATA), 32'(d));
        check_eq("rs_kept", 32'(LCD_RS), 32'(rs));
    endtask

    initial begin
        exp_t e;
        int   n0;
        bit   seen;

        repeat (3) @(negedge iCLK);
        check_eq("rst_done", 32'(oDone), 0);
        check_eq("rst_data", 32'(LCD_DATA), 0);
        check_eq("rst_rw", 32'(LCD_RW), 0);
        check_eq("rst_en", 32'(LCD_EN), 0);
        check_eq("rst_rs", 32'(LCD_RS), 0);
        reset = 1'b0;

        do_write(8'h38, 1'b0, 8'h38, LAT_NORM, 0);
        do_write(8'h01, 1'b0, 8'h01, LAT_CLR, 0);
        do_write(8'h55, 1'b1, 8'h55, LAT_NORM, 10000);
        do_write(8'h44, 1'b1, 8'h4E, LAT_NORM, 0);
        do_write(8'h03, 1'b0, 8'h03, LAT_CLR, 3);
        do_write(8'h04, 1'b0, 8'h04, LAT_NORM, 0);
        do_write(8'h02, 1'b1, 8'h02, LAT_NORM, 0);

        // Abort during EXEC of 0x0C.
        @(negedge iCLK);
        iDATA  = 8'h0C;
        iRS    = 1'b0;
        iStart = 1'b1;
        e.acc  = cyc + 1;
        e.lat  = LAT_NORM;
        e.data = 8'h0C;
        e.rs   = 1'b0;
        sb_q.push_back(e);
        while (cyc < e.acc + 100) @(negedge iCLK);
        reset  = 1'b1;
        iStart = 1'b0;
        @(negedge iCLK);
        check_eq("abort_done", 32'(oDone), 0);
        check_eq("abort_data", 32'(LCD_DATA), 0);
        check_eq("abort_rw", 32'(LCD_RW), 0);
        check_eq("abort_en", 32'(LCD_EN), 0);
        check_eq("abort_rs", 32'(LCD_RS), 0);
        sb_q.delete();
        reset = 1'b0;
        n0    = en_pulses;
        seen  = 1'b0;
        for (int i = 0; i < LAT_NORM + 50; i++) begin
            @(negedge iCLK);
            if (oDone || LCD_EN) seen = 1'b1;
        end
        check_eq("abort_quiet", 32'(seen), 0);
        check_eq("abort_no_pulse", en_pulses - n0, 0);
        do_write(8'h06, 1'b0, 8'h06, LAT_NORM, 0);

        // All-zero timing parameters: every state lasts one cycle.
        @(negedge iCLK);
        m_data  = 8'h38;
        m_rs    = 1'b1;
        m_start = 1'b1;
        @(negedge iCLK);
        check_eq("min_setup_en", 32'(m_en), 0);
        check_eq("min_data", 32'(m_lcd_data), 32'h38);
        @(negedge iCLK);
        check_eq("min_strobe_en", 32'(m_en), 1);
        @(negedge iCLK);
        check_eq("min_hold_en", 32'(m_en), 0);
        @(negedge iCLK);
        check_eq("min_exec_done", 32'(m_done), 0);
        @(negedge iCLK);
        check_eq("min_latency_done", 32'(m_done), 1);
        m_start = 1'b0;
        @(negedge iCLK);
        check_eq("min_done_fall", 32'(m_done), 0);

        check_eq("sb_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
